// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use hazard
// control for the pipelined MIPS datapath. A detected load-use hazard holds
// PC and IF/ID and bubbles ID/EX for 1+LOAD_LAT cycles. A saturating counter
// records the number of stall cycles.
module fwd_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NSRC*ADDR_W-1:0]   id_src,
  input  logic [NSRC-1:0]          id_src_used,
  input  logic [NSRC*ADDR_W-1:0]   ex_src,
  input  logic [ADDR_W-1:0]        ex_dest,
  input  logic                     ex_regwrite,
  input  logic                     ex_memread,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic                     mem_regwrite,
  input  logic [ADDR_W-1:0]        wb_dest,
  input  logic                     wb_regwrite,
  input  logic                     flush,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic                     stall,
  output logic                     bubble,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  // Remaining HOLD cycles; LOAD_LAT is at most 7.
  localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [NSRC*2-1:0] fwd_raw;
  logic              hz;
  logic              stall_int;

  // Per-operand forwarding select; EX/MEM wins whenever its full condition holds.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    fwd_raw = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (mem_regwrite && (mem_dest != '0) &&
          (mem_dest == ex_src[i*ADDR_W +: ADDR_W])) begin
        fwd_raw[i*2 +: 2] = 2'b10;
      end else if (wb_regwrite && (wb_dest != '0) &&
                   (wb_dest == ex_src[i*ADDR_W +: ADDR_W])) begin
        fwd_raw[i*2 +: 2] = 2'b01;
      end
    end
  end

  // Load-use hazard: a load in EX writes a register that ID actually reads.
  always_comb begin
    logic src_hit;
    src_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_src_used[i] && (id_src[i*ADDR_W +: ADDR_W] == ex_dest)) begin
        src_hit = 1'b1;
      end
    end
    hz = id_valid && ex_memread && ex_regwrite && (ex_dest != '0) && src_hit;
  end

  // Stall FSM next-state and output; flush overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_int = 1'b0;
    case (state)
      IDLE: begin
        if (hz && !flush) begin
          stall_int = 1'b1;
          if (LOAD_LAT > 0) begin
            state_nxt = HOLD;
            cnt_nxt   = LAT_INIT;
          end
        end
      end
      HOLD: begin
        if (!flush) begin
          stall_int = 1'b1;
          cnt_nxt   = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Outputs are forced quiet while reset is held.
  assign fwd_sel = rst_n ? fwd_raw : '0;
  assign stall   = rst_n & stall_int;
  assign bubble  = stall;

  // FSM state and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating count of stall cycles for performance monitoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
